// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer for the 8-bit pipelined MIPS core: drains the
// pipeline, vectors the PC to the handler, saves the return address and restores it on reti.
module interrupt_sequencer #(
    parameter logic [7:0]  VECTOR_ADDR  = 8'hF0,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic        IE_RESET     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       interrupt,
    input  logic [7:0] Current_Address,
    input  logic       ie_set,
    input  logic       ie_clr,
    input  logic       reti,
    output logic       stall,
    output logic       flush,
    output logic       pc_load,
    output logic [7:0] pc_load_addr,
    output logic [7:0] epc,
    output logic       int_ack,
    output logic       in_service,
    output logic       ie
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_VECTOR,
        S_SERVICE,
        S_RETURN
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_next;
    logic       int_q;
    logic       pending, pending_next;
    logic       ie_r, ie_next;
    logic [7:0] epc_r, epc_next;
    logic [2:0] cnt, cnt_next;
    logic       int_edge;

    assign int_edge = interrupt & ~int_q;
    assign ie       = ie_r;
    assign epc      = epc_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            int_q   <= 1'b0;
            pending <= 1'b0;
            ie_r    <= IE_RESET;
            epc_r   <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            int_q   <= interrupt;
            pending <= pending_next;
            ie_r    <= ie_next;
            epc_r   <= epc_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        epc_next     = epc_r;
        pending_next = pending | int_edge;
        ie_next      = ie_r;
        if (ie_clr)
            ie_next = 1'b0;
        else if (ie_set)
            ie_next = 1'b1;

        stall        = 1'b0;
        flush        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        int_ack      = 1'b0;
        in_service   = 1'b0;

        case (state)
            S_IDLE: begin
                // The instruction in fetch is squashed and re-fetched from epc on return.
                if (pending & ie_r) begin
                    flush      = 1'b1;
                    state_next = S_DRAIN;
                    epc_next   = Current_Address;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (cnt == 3'd0)
                    state_next = S_VECTOR;
                else
                    cnt_next = cnt - 3'd1;
            end
            S_VECTOR: begin
                pc_load      = 1'b1;
                pc_load_addr = VECTOR_ADDR;
                int_ack      = 1'b1;
                pending_next = int_edge;
                ie_next      = 1'b0;
                state_next   = S_SERVICE;
            end
            S_SERVICE: begin
                in_service = 1'b1;
                if (reti)
                    state_next = S_RETURN;
            end
            S_RETURN: begin
                pc_load      = 1'b1;
                pc_load_addr = epc_r;
                flush        = 1'b1;
                in_service   = 1'b1;
                ie_next      = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a timeline model of interrupt entry/exit checked
// every cycle, plus directed scenarios with literal expectations.
module tb_interrupt_sequencer;

    localparam logic [7:0]  VEC   = 8'hF0;
    localparam int unsigned DRAIN = 3;
    localparam logic        IE_R  = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       interrupt;
    logic [7:0] Current_Address;
    logic       ie_set, ie_clr, reti;
    logic       stall, flush, pc_load, int_ack, in_service, ie;
    logic [7:0] pc_load_addr, epc;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    interrupt_sequencer #(
        .VECTOR_ADDR (VEC),
        .DRAIN_CYCLES(DRAIN),
        .IE_RESET    (IE_R)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .interrupt      (interrupt),
        .Current_Address(Current_Address),
        .ie_set         (ie_set),
        .ie_clr         (ie_clr),
        .reti           (reti),
        .stall          (stall),
        .flush          (flush),
        .pc_load        (pc_load),
        .pc_load_addr   (pc_load_addr),
        .epc            (epc),
        .int_ack        (int_ack),
        .in_service     (in_service),
        .ie             (ie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model: a queue of scheduled special cycles (1=drain bubble, 2=vector, 3=return);
    // an empty queue means either idle or running the handler.
    int         plan[$];
    bit         m_pending = 0, m_ie = IE_R, m_int_q = 0, m_serv = 0;
    logic [7:0] m_epc = 8'h00;

    always @(posedge clk or posedge reset) begin
        bit e, p_old, ie_old, ie_dec;
        int cur;
        if (reset) begin
            plan.delete();
            m_pending = 0; m_ie = IE_R; m_int_q = 0; m_serv = 0; m_epc = 8'h00;
        end else begin
            e = interrupt && !m_int_q;
            m_int_q = interrupt;
            p_old = m_pending;
            ie_old = m_ie;
            ie_dec = ie_clr ? 1'b0 : (ie_set ? 1'b1 : m_ie);
            cur = (plan.size() != 0) ? plan[0] : 0;
            if (cur == 2) begin
                m_pending = e; m_ie = 0; m_serv = 1; void'(plan.pop_front());
            end else if (cur == 3) begin
                m_pending = p_old | e; m_ie = 1; m_serv = 0; void'(plan.pop_front());
            end else if (cur == 1) begin
                m_pending = p_old | e; m_ie = ie_dec; void'(plan.pop_front());
            end else begin
                m_pending = p_old | e; m_ie = ie_dec;
                if (m_serv) begin
                    if (reti) plan.push_back(3);
                end else if (p_old && ie_old) begin
                    m_epc = Current_Address;
                    repeat (DRAIN) plan.push_back(1);
                    plan.push_back(2);
                end
            end
        end
    end

    always @(negedge clk) begin
        int cur;
        if (checking) begin
            cur = (plan.size() != 0) ? plan[0] : 0;
            check("stall", 8'(stall), 8'(cur == 1));
            check("pc_load", 8'(pc_load), 8'(cur == 2 || cur == 3));
            check("pc_load_addr", pc_load_addr, (cur == 2) ? VEC : ((cur == 3) ? m_epc : 8'h00));
            check("int_ack", 8'(int_ack), 8'(cur == 2));
            check("in_service", 8'(in_service), 8'(cur == 3 || (cur == 0 && m_serv)));
            check("flush", 8'(flush), 8'(cur == 3 || (cur == 0 && !m_serv && m_pending && m_ie)));
            check("ie", 8'(ie), 8'(m_ie));
            check("epc", epc, m_epc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    initial begin
        reset = 1'b1; interrupt = 1'b0; Current_Address = 8'h12;
        ie_set = 1'b0; ie_clr = 1'b0; reti = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("lit_reset_ie", 8'(ie), 8'h01);
        check("lit_reset_epc", epc, 8'h00);
        check("lit_reset_stall", 8'(stall), 8'h00);
        check("lit_reset_pc_load", 8'(pc_load), 8'h00);
        check("lit_reset_in_service", 8'(in_service), 8'h00);
        checking = 1;
        repeat (10) begin
            step();
            check("lit_quiet_stall", 8'(stall), 8'h00);
        end

        // Entry
        interrupt = 1'b1; step();
        check("lit_entry_flush", 8'(flush), 8'h01);
        check("lit_entry_nostall", 8'(stall), 8'h00);
        repeat (DRAIN) begin
            step();
            check("lit_drain_stall", 8'(stall), 8'h01);
        end
        step();
        check("lit_vec_ack", 8'(int_ack), 8'h01);
        check("lit_vec_load", 8'(pc_load), 8'h01);
        check("lit_vec_addr", pc_load_addr, 8'hF0);
        check("lit_vec_stall", 8'(stall), 8'h00);
        step();
        interrupt = 1'b0;
        check("lit_svc_in_service", 8'(in_service), 8'h01);
        check("lit_svc_ie", 8'(ie), 8'h00);
        check("lit_svc_epc", epc, 8'h12);

        // Return
        repeat (3) step();
        pulse_reti();
        check("lit_ret_load", 8'(pc_load), 8'h01);
        check("lit_ret_addr", pc_load_addr, 8'h12);
        check("lit_ret_flush", 8'(flush), 8'h01);
        step();
        check("lit_after_ret_ie", 8'(ie), 8'h01);
        check("lit_after_ret_in_service", 8'(in_service), 8'h00);

        // Edge during service is held and taken right after return
        interrupt = 1'b1; step(); interrupt = 1'b0;
        repeat (DRAIN + 2) step();
        step();
        interrupt = 1'b1; step(); interrupt = 1'b0;
        check("lit_no_nest_stall", 8'(stall), 8'h00);
        check("lit_no_nest_svc", 8'(in_service), 8'h01);
        pulse_reti();
        step();
        check("lit_b2b_flush", 8'(flush), 8'h01);
        step();
        check("lit_b2b_stall", 8'(stall), 8'h01);
        check("lit_b2b_epc", epc, 8'h12);
        repeat (DRAIN + 1) step();
        pulse_reti();
        step();

        // Masked request waits for ie_set
        ie_clr = 1'b1; step(); ie_clr = 1'b0;
        check("lit_ie_clr", 8'(ie), 8'h00);
        interrupt = 1'b1; step(); interrupt = 1'b0;
        repeat (5) begin
            check("lit_masked_stall", 8'(stall), 8'h00);
            check("lit_masked_flush", 8'(flush), 8'h00);
            step();
        end
        ie_set = 1'b1; step(); ie_set = 1'b0;
        check("lit_unmask_flush", 8'(flush), 8'h01);
        step();
        check("lit_unmask_stall", 8'(stall), 8'h01);
        step();

        // Async reset mid-drain
        #2 reset = 1'b1;
        #1;
        check("lit_rst_stall", 8'(stall), 8'h00);
        check("lit_rst_flush", 8'(flush), 8'h00);
        check("lit_rst_ie", 8'(ie), 8'h01);
        @(posedge clk); #3 reset = 1'b0;
        step();
        check("lit_rst_pending_lost", 8'(flush), 8'h00);
        pulse_reti();
        check("lit_idle_reti_load", 8'(pc_load), 8'h00);
        step();
        check("lit_idle_reti_load2", 8'(pc_load), 8'h00);

        // ie_set and ie_clr together
        ie_set = 1'b1; ie_clr = 1'b1; step(); ie_set = 1'b0; ie_clr = 1'b0;
        check("lit_ie_both", 8'(ie), 8'h00);
        ie_set = 1'b1; step(); ie_set = 1'b0;
        check("lit_ie_set", 8'(ie), 8'h01);

        // Edge sampled on the vector edge survives the pending clear
        interrupt = 1'b1; step(); interrupt = 1'b0;
        repeat (DRAIN) step();
        step();
        check("lit_vec2_ack", 8'(int_ack), 8'h01);
        interrupt = 1'b1; step(); interrupt = 1'b0;
        step();
        pulse_reti();
        step();
        check("lit_vec_edge_kept", 8'(flush), 8'h01);
        repeat (DRAIN + 2) step();
        pulse_reti();
        repeat (4) step();

        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
